// File: rtl/logic_op_sweeper_pkg.sv
// Shared definitions for the logic-function sweeper: op encoding, FSM states
// and the single-bit function used by the per-bit evaluator.
package logic_op_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_NAND   = 3'd2;
  localparam logic [2:0] OP_NOR    = 3'd3;
  localparam logic [2:0] OP_XOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_NIMP_B = 3'd6;  // a | ~b
  localparam logic [2:0] OP_NIMP_A = 3'd7;  // ~a | b

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic bit_op(input logic [2:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XOR:    r = a ^ b;
      OP_XNOR:   r = ~(a ^ b);
      OP_NIMP_B: r = a | ~b;
      OP_NIMP_A: r = ~a | b;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_sweeper_if.sv
// Control and row-stream bundle of the sweeper; master is the sweeper side,
// slave is the controller/consumer side.
interface logic_op_sweeper_if #(
  parameter int WIDTH = 2
);
  localparam int CNT_W = 2 * WIDTH + 4;

  logic             start;
  logic [2:0]       op;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_s;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] ones_count;

  modport master (
    input  start, op, out_ready,
    output out_valid, out_a, out_b, out_s, busy, done, ones_count
  );

  modport slave (
    output start, op, out_ready,
    input  out_valid, out_a, out_b, out_s, busy, done, ones_count
  );
endinterface

// File: rtl/logic_op_sweeper_eval.sv
// Purely combinational bitwise evaluation of the selected two-input function.
module logic_op_eval
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 2
) (
  output logic [WIDTH-1:0] s,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign s[gi] = bit_op(op, a[gi], b[gi]);
  end

endmodule

// File: rtl/logic_op_sweeper.sv
// Sweeps all {a,b} operand pairs in ascending order, streams (a, b, f(a,b))
// rows with valid/ready and totals the 1 bits of every accepted result.
module logic_op_sweeper
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 2 * WIDTH + 4
) (
  input logic                 clk,
  input logic                 reset,
  logic_op_sweeper_if.master  bus
);

  state_e           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [2:0]       op_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] s_w;
  logic             last_row;
  logic             accept;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  logic_op_eval #(.WIDTH(WIDTH)) u_eval (
    .s  (s_w),
    .op (op_reg),
    .a  (a_reg),
    .b  (b_reg)
  );

  assign last_row = (&a_reg) & (&b_reg);
  assign accept   = (state_reg == ST_RUN) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN:  if (accept && last_row) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state_reg)
      ST_RUN: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  // Operands advance only on a handshake, so backpressure freezes the row.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= OP_AND;
      count_reg <= '0;
    end else begin
      if (state_reg == ST_IDLE && bus.start) begin
        op_reg    <= bus.op;
        a_reg     <= '0;
        b_reg     <= '0;
        count_reg <= '0;
      end else if (accept) begin
        count_reg <= count_reg + popcount(s_w);
        if (!last_row) {a_reg, b_reg} <= {a_reg, b_reg} + (2 * WIDTH)'(1);
      end
    end
  end

  assign bus.out_a      = a_reg;
  assign bus.out_b      = b_reg;
  assign bus.out_s      = s_w;
  assign bus.ones_count = count_reg;

endmodule

// File: doc/logic_op_sweeper.md
Name: logic_op_sweeper

Overview:
- Parametrised, sequential successor to the single-bit two-input logic-function blocks.
- Sweeps every combination of two WIDTH-bit operands (a, b) and evaluates a selectable bitwise logic function on each pair.
- Streams each row (a, b, s) over a valid/ready interface and accumulates the total number of 1 bits in s over the whole sweep.
- Acts as a self-checking truth-table generator for the guide-series test benches.

Parameters:
- WIDTH, 2, operand/result width in bits; legal range 1..8.
- CNT_W, 2*WIDTH+4, width of ones_count; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a sweep; sampled only in IDLE.
- op  in  3  function select, sampled at start. Encoding: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 a|~b, 7 ~a|b.
- out_ready  in  1  consumer accepts the current row.
- out_valid  out  1  the current row is valid.
- out_a  out  WIDTH  operand a of the current row.
- out_b  out  WIDTH  operand b of the current row.
- out_s  out  WIDTH  bitwise f(op_q, out_a, out_b).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a sweep completes.
- ones_count  out  CNT_W  sum of popcount(out_s) over all accepted rows.

Behaviour:
- Only one clock domain exists: clk. The reset is synchronous and active-high. These two facts are fixed.
- Reset state:
  - FSM in IDLE.
  - out_valid=0, busy=0, done=0.
  - out_a=0, out_b=0, ones_count=0, op_q=0.
- FSM states:
  - IDLE -> RUN on start. In that same cycle: op_q<=op, out_a<=0, out_b<=0, ones_count<=0.
  - RUN: out_valid=1, busy=1.
    - On out_valid & out_ready: ones_count += popcount(out_s).
    - If out_a and out_b are both all-ones, go to DONE.
    - Otherwise increment the concatenation {out_a, out_b} by 1. out_b is the low half; it wraps to 0 and carries into out_a.
  - DONE: done=1, out_valid=0, busy=0; unconditionally return to IDLE next cycle.
- Latency:
  - start sampled at edge N -> first row (0,0) valid from cycle N+1.
  - Last handshake at edge M -> done high during cycle M+1.
- Row count: exactly 2^(2*WIDTH) handshakes per sweep, in ascending {a,b} order.
- Backpressure: while out_ready=0 in RUN, out_a, out_b, out_s and ones_count hold. No row is skipped or duplicated.
- out_s:
  - Combinational from the registered out_a, out_b and op_q.
  - Stable while out_valid is held.
  - Driven even when out_valid=0; consumers ignore it.
- op changes after start are ignored until the next start.
- start while busy or in DONE is ignored; it is not queued.
- ones_count:
  - Holds its final value after DONE until the next accepted start clears it.
  - Never overflows: the maximum is WIDTH*2^(2*WIDTH) < 2^CNT_W.
- reset in any state, including mid-sweep or during DONE:
  - The next cycle is in the reset state.
  - done is not asserted for the aborted sweep.

Decomposition:
- logic_op_pkg holds:
  - the op encoding localparams (OP_AND..OP_NIMP_A);
  - the FSM state encoding (ST_IDLE, ST_RUN, ST_DONE).
- One sub-module, logic_op_eval: purely combinational, parameter WIDTH, ports (s, op, a, b). It is instantiated once for out_s.
- Popcount is a function inside logic_op_sweeper.

Test Plan:
- WIDTH=1, op=6, out_ready=1 -> rows (a,b,s) = (0,0,1), (0,1,0), (1,0,1), (1,1,1); then done one cycle after the 4th row; ones_count=3.
- WIDTH=2, op=0 (AND), out_ready=1 -> 16 rows in order 0x0..0xF of {a,b}; done; ones_count=8. Repeat with op=4 (XOR) -> ones_count=16; with op=3 (NOR) -> ones_count=8.
- WIDTH=2, op=1, out_ready held low for 3 cycles while row {a,b}=0x5 is presented -> out_a=1, out_b=1, out_s=1 held; ones_count unchanged; then rows continue at 0x6; final ones_count=24.
- WIDTH=2, start pulsed again mid-sweep with op=5, and op toggled -> ignored; the sweep completes with the original op and its expected ones_count.
- WIDTH=2, reset asserted at row 0x7 -> next cycle out_valid=0, busy=0, ones_count=0, out_a=out_b=0; done never pulses; a fresh start then runs a full 16-row sweep.
- Latency check: start at edge N -> out_valid=1 at N+1 with row (0,0); last accepted row at edge M -> done=1 only in cycle M+1; busy=0 from M+1 onward.
